kgp_alu_issue: RTL and testbench

Issue/sequencing control for the KGP-RISC ALU: the driving end of the ALU's operation/operand/flag interface. It accepts one decoded instruction over a valid/ready handshake, selects operands, and drives the 4-bit ALU operation code for exactly one cycle. It samples the result and flags, then emits either a register writeback or a branch decision. It sits between the decode stage and the register file/PC logic and guarantees that the ALU's registered carry flag is only updated by real add instructions.

---
 rtl/kgp_alu_issue.sv | 247 ++++++++++++++++++++++++
 tb/tb_kgp_alu_issue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_alu_issue.sv
// kgp_alu_issue: issue/sequencing control for the KGP-RISC ALU.
// Accepts one decoded instruction (valid/ready), drives the ALU for one EXEC
// cycle, captures result and flags, then strobes writeback, branch or error.
// The ALU op code is 4'd0 only while an add executes, so the ALU's carry
// register only ever reflects real add instructions.
// Optional: define KGP_ALU_ISSUE_STATS_EN to add issued_count/err_count ports.
module kgp_alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [1:0]  instr_class,
  input  logic [3:0]  instr_func,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_operation,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_carry,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic        br_taken,
  output logic        err
`ifdef KGP_ALU_ISSUE_STATS_EN
  ,
  output logic [31:0] issued_count,
  output logic [15:0] err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_WB  = 2'd0,
    KIND_BR  = 2'd1,
    KIND_ERR = 2'd2
  } kind_e;

  localparam logic [3:0] OP_IDLE = 4'd15;
  localparam logic [3:0] OP_PASS = 4'd8;

  state_e      r_state;
  state_e      w_next;
  logic        w_accept;
  logic        r_ready;

  kind_e       r_kind;
  logic [2:0]  r_cond;
  logic [4:0]  r_rd;
  logic [3:0]  r_alu_op;
  logic [31:0] r_alu_in1;
  logic [31:0] r_alu_in2;

  kind_e       w_kind;
  logic [3:0]  w_op;
  logic [31:0] w_in1;
  logic [31:0] w_in2;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_br_valid;
  logic        r_br_taken;
  logic        r_err;

  // Branch condition evaluated on the flags captured at the end of EXEC.
  function automatic logic cond_eval(input logic [2:0] cond, input logic z,
                                     input logic s, input logic c);
    logic t;
    case (cond)
      3'd0:    t = 1'b1;
      3'd1:    t = s;
      3'd2:    t = z;
      3'd3:    t = ~z;
      3'd4:    t = c;
      3'd5:    t = ~c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Next-state logic; an instruction is only taken while idle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          w_next   = ST_EXEC;
          w_accept = 1'b1;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Decode the incoming instruction into response kind and ALU drive values.
  always_comb begin
    w_kind = KIND_ERR;
    w_op   = OP_IDLE;
    w_in1  = 32'd0;
    w_in2  = 32'd0;
    if ((instr_class == 2'd0 || instr_class == 2'd1) && instr_func <= 4'd8) begin
      w_kind = KIND_WB;
      w_op   = instr_func;
      w_in1  = rs_val;
      w_in2  = (instr_class == 2'd0) ? rt_val : imm;
    end else if (instr_class == 2'd2 && instr_func <= 4'd5) begin
      w_kind = KIND_BR;
      w_op   = OP_PASS;
      w_in1  = rs_val;
      w_in2  = 32'd0;
    end else begin
      w_kind = KIND_ERR;
      w_op   = OP_IDLE;
      w_in1  = 32'd0;
      w_in2  = 32'd0;
    end
  end

  // State register; ready is registered alongside it and high only in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
    end
  end

  // Latch the instruction on accept and drive the ALU only during EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kind    <= KIND_ERR;
      r_cond    <= 3'd0;
      r_rd      <= 5'd0;
      r_alu_op  <= OP_IDLE;
      r_alu_in1 <= 32'd0;
      r_alu_in2 <= 32'd0;
    end else if (w_accept) begin
      r_kind    <= w_kind;
      r_cond    <= instr_func[2:0];
      r_rd      <= rd;
      r_alu_op  <= w_op;
      r_alu_in1 <= w_in1;
      r_alu_in2 <= w_in2;
    end else if (r_state == ST_EXEC) begin
      r_alu_op  <= OP_IDLE;
      r_alu_in1 <= 32'd0;
      r_alu_in2 <= 32'd0;
    end else begin
      r_alu_op  <= r_alu_op;
      r_alu_in1 <= r_alu_in1;
      r_alu_in2 <= r_alu_in2;
    end
  end

  // Capture ALU result/flags at the end of EXEC; strobes live for RESP only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_br_valid <= 1'b0;
      r_br_taken <= 1'b0;
      r_err      <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_wb_valid <= (r_kind == KIND_WB);
      r_br_valid <= (r_kind == KIND_BR);
      r_err      <= (r_kind == KIND_ERR);
      if (r_kind == KIND_WB) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= alu_out;
      end else begin
        r_wb_rd   <= r_wb_rd;
        r_wb_data <= r_wb_data;
      end
      if (r_kind == KIND_BR) begin
        r_br_taken <= cond_eval(r_cond, alu_zero, alu_sign, alu_carry);
      end else begin
        r_br_taken <= r_br_taken;
      end
    end else begin
      r_wb_valid <= 1'b0;
      r_br_valid <= 1'b0;
      r_err      <= 1'b0;
    end
  end

`ifdef KGP_ALU_ISSUE_STATS_EN
  logic [31:0] r_issued_count;
  logic [15:0] r_err_count;

  // Statistics: issued instructions wrap, error count saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issued_count <= 32'd0;
      r_err_count    <= 16'd0;
    end else if (r_state == ST_RESP) begin
      if (r_wb_valid || r_br_valid) begin
        r_issued_count <= r_issued_count + 32'd1;
      end else begin
        r_issued_count <= r_issued_count;
      end
      if (r_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end else begin
        r_err_count <= r_err_count;
      end
    end else begin
      r_issued_count <= r_issued_count;
      r_err_count    <= r_err_count;
    end
  end

  assign issued_count = r_issued_count;
  assign err_count    = r_err_count;
`endif

  assign instr_ready   = r_ready;
  assign alu_operation = r_alu_op;
  assign alu_in1       = r_alu_in1;
  assign alu_in2       = r_alu_in2;
  assign wb_valid      = r_wb_valid;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign br_valid      = r_br_valid;
  assign br_taken      = r_br_taken;
  assign err           = r_err;

endmodule

// File: tb/tb_kgp_alu_issue.sv
// Self-checking bench for kgp_alu_issue: a small ALU stub with a registered
// carry, directed cases, a mid-instruction reset and randomized instructions
// checked against a reference model built from the instruction rules.
module tb_kgp_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_class;
  logic [3:0]  instr_func;
  logic [31:0] rs_val, rt_val, imm;
  logic [4:0]  rd;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_operation;
  logic [31:0] alu_out;
  logic        alu_zero, alu_sign, alu_carry;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        br_valid, br_taken, err;
`ifdef KGP_ALU_ISSUE_STATS_EN
  logic [31:0] issued_count;
  logic [15:0] err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_carry   = 1'b0;
  logic [31:0] m_wb_data = 32'd0;
  logic [4:0]  m_wb_rd   = 5'd0;
  logic        m_br      = 1'b0;
  int          m_issued  = 0;
  int          m_errs    = 0;

  always #5 clk = ~clk;

  kgp_alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_class(instr_class), .instr_func(instr_func), .rs_val(rs_val),
    .rt_val(rt_val), .imm(imm), .rd(rd), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_operation(alu_operation), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .alu_carry(alu_carry), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .br_valid(br_valid), .br_taken(br_taken),
    .err(err)
`ifdef KGP_ALU_ISSUE_STATS_EN
    , .issued_count(issued_count), .err_count(err_count)
`endif
  );

  // ALU behaviour: 0 add, 1 negate op2, 2 and, 3 or, 4 xor, 5 sll, 6 sra, 7 srl, 8 pass
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return ~b + 32'd1;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b;
      4'd6:    return $unsigned($signed(a) >>> b);
      4'd7:    return a >> b;
      4'd8:    return a;
      default: return 32'd0;
    endcase
  endfunction

  logic        stub_carry = 1'b0;
  logic [32:0] add_full;
  assign alu_out   = alu_fn(alu_operation, alu_in1, alu_in2);
  assign alu_zero  = (alu_out == 32'd0);
  assign alu_sign  = alu_out[31];
  assign add_full  = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_carry = stub_carry;

  // ALU carry register: loads only while the add op code is presented
  always @(posedge clk) begin
    if (alu_operation == 4'd0) stub_carry <= add_full[32];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef KGP_ALU_ISSUE_STATS_EN
    check_val("issued_count", issued_count, m_issued);
    check_val("err_count", {16'd0, err_count}, m_errs);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    check_val({tag, "_op"}, {28'd0, alu_operation}, 32'd15);
    check_val({tag, "_in1"}, alu_in1, 32'd0);
    check_val({tag, "_in2"}, alu_in2, 32'd0);
    check_val({tag, "_strobes"}, {29'd0, wb_valid, br_valid, err}, 32'd0);
    check_val({tag, "_brt"}, {31'd0, br_taken}, 32'd0);
    check_val({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    check_val({tag, "_wbdata"}, wb_data, 32'd0);
    check_stats();
  endtask

  // Issue one instruction and check EXEC, RESP and the following IDLE cycle.
  task automatic run_instr(input logic [1:0] cls, input logic [3:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] im, input logic [4:0] r,
                           input bit hold_valid);
    bit          is_alu, is_br;
    logic [3:0]  exp_op;
    logic [31:0] op2, exp_res;
    logic [32:0] sum;
    logic        exp_taken;
    is_alu = (cls <= 2'd1) && (fn <= 4'd8);
    is_br  = (cls == 2'd2) && (fn <= 4'd5);
    exp_op = is_alu ? fn : (is_br ? 4'd8 : 4'd15);
    op2    = (cls == 2'd0) ? rt : im;

    @(negedge clk);
    check_val("idle_ready", {31'd0, instr_ready}, 32'd1);
    instr_class = cls; instr_func = fn; rs_val = rs; rt_val = rt; imm = im; rd = r;
    instr_valid = 1'b1;

    @(posedge clk); #1;
    check_val("exec_op", {28'd0, alu_operation}, {28'd0, exp_op});
    if (is_alu || is_br) check_val("exec_in1", alu_in1, rs);
    if (is_alu) check_val("exec_in2", alu_in2, op2);
    check_val("exec_ready", {31'd0, instr_ready}, 32'd0);
    check_val("exec_strobes", {29'd0, wb_valid, br_valid, err}, 32'd0);
    if (hold_valid) begin
      instr_class = 2'($urandom); instr_func = 4'($urandom);
      rs_val = $urandom; rt_val = $urandom; imm = $urandom; rd = 5'($urandom);
    end else begin
      instr_valid = 1'b0;
    end

    exp_res = alu_fn(fn, rs, op2);
    case (fn)
      4'd0: exp_taken = 1'b1;
      4'd1: exp_taken = rs[31];
      4'd2: exp_taken = (rs == 32'd0);
      4'd3: exp_taken = (rs != 32'd0);
      4'd4: exp_taken = m_carry;
      4'd5: exp_taken = !m_carry;
      default: exp_taken = 1'b0;
    endcase
    if (is_alu) begin m_wb_data = exp_res; m_wb_rd = r; m_issued++; end
    else if (is_br) begin m_br = exp_taken; m_issued++; end
    else m_errs++;
    if (is_alu && fn == 4'd0) begin
      sum = {1'b0, rs} + {1'b0, op2};
      m_carry = sum[32];
    end

    @(posedge clk); #1;
    instr_valid = 1'b0;
    check_val("resp_wb_valid", {31'd0, wb_valid}, {31'd0, is_alu});
    check_val("resp_br_valid", {31'd0, br_valid}, {31'd0, is_br});
    check_val("resp_err", {31'd0, err}, {31'd0, !(is_alu || is_br)});
    check_val("resp_wb_data", wb_data, m_wb_data);
    check_val("resp_wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
    check_val("resp_br_taken", {31'd0, br_taken}, {31'd0, m_br});
    check_val("resp_op", {28'd0, alu_operation}, 32'd15);
    check_val("resp_in", alu_in1 | alu_in2, 32'd0);
    check_val("resp_ready", {31'd0, instr_ready}, 32'd0);

    @(posedge clk); #1;
    check_val("post_strobes", {29'd0, wb_valid, br_valid, err}, 32'd0);
    check_val("post_ready", {31'd0, instr_ready}, 32'd1);
    check_val("post_op", {28'd0, alu_operation}, 32'd15);
    check_val("hold_wb_data", wb_data, m_wb_data);
    check_val("hold_wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
    check_val("hold_br_taken", {31'd0, br_taken}, {31'd0, m_br});
    check_val("carry_reg", {31'd0, alu_carry}, {31'd0, m_carry});
    check_stats();
  endtask

  // Start an add, then pull reset during EXEC (phase 0) or RESP (phase 1).
  task automatic reset_mid(input int phase);
    logic [32:0] sum;
    @(negedge clk);
    instr_class = 2'd0; instr_func = 4'd0; rs_val = 32'hFFFF_FFFF;
    rt_val = 32'd5; imm = 32'd0; rd = 5'd9; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (phase == 1) begin
      @(posedge clk); #1;
      sum = {1'b0, rs_val} + {1'b0, rt_val};
      m_carry = sum[32];
    end
    #1 rst = 1'b0;
    #1;
    m_wb_data = 32'd0; m_wb_rd = 5'd0; m_br = 1'b0; m_issued = 0; m_errs = 0;
    check_reset_vals(phase == 1 ? "rst_resp" : "rst_exec");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("after_rst_strobes", {29'd0, wb_valid, br_valid, err}, 32'd0);
      check_val("after_rst_ready", {31'd0, instr_ready}, 32'd1);
      check_val("after_rst_op", {28'd0, alu_operation}, 32'd15);
    end
    check_val("after_rst_carry", {31'd0, alu_carry}, {31'd0, m_carry});
  endtask

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr_class = 2'd0; instr_func = 4'd0;
    rs_val = 32'd0; rt_val = 32'd0; imm = 32'd0; rd = 5'd0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    // add with carry out, then bcy
    run_instr(2'd0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3, 1'b0);
    check_val("tp_add_data", wb_data, 32'd0);
    check_val("tp_add_rd", {27'd0, wb_rd}, 32'd3);
    run_instr(2'd2, 4'd4, 32'd7, 32'd0, 32'd0, 5'd0, 1'b0);
    check_val("tp_bcy_taken", {31'd0, br_taken}, 32'd1);
    // arithmetic shift right with immediate
    run_instr(2'd1, 4'd6, 32'h8000_0000, 32'd0, 32'd4, 5'd7, 1'b1);
    check_val("tp_sra_data", wb_data, 32'hF800_0000);
    // branch conditions
    run_instr(2'd2, 4'd1, 32'h8000_0001, 32'd0, 32'd0, 5'd0, 1'b0);
    check_val("tp_bltz", {31'd0, br_taken}, 32'd1);
    run_instr(2'd2, 4'd2, 32'd1, 32'd0, 32'd0, 5'd0, 1'b0);
    check_val("tp_bz", {31'd0, br_taken}, 32'd0);
    run_instr(2'd2, 4'd3, 32'd1, 32'd0, 32'd0, 5'd0, 1'b0);
    check_val("tp_bnz", {31'd0, br_taken}, 32'd1);
    // illegal encodings must not touch the carry
    run_instr(2'd0, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd1, 1'b0);
    run_instr(2'd3, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd1, 1'b0);
    run_instr(2'd2, 4'd6, 32'd0, 32'd0, 32'd0, 5'd1, 1'b0);
    // add without carry then bncy
    run_instr(2'd0, 4'd0, 32'd10, 32'd20, 32'd0, 5'd4, 1'b0);
    run_instr(2'd2, 4'd5, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    check_val("tp_bncy", {31'd0, br_taken}, 32'd1);

    reset_mid(0);
    reset_mid(1);

    // 5 legal plus 2 illegal from a clean reset
    run_instr(2'd0, 4'd2, 32'hF0F0, 32'hFF00, 32'd0, 5'd1, 1'b0);
    run_instr(2'd1, 4'd3, 32'h1, 32'd0, 32'h10, 5'd2, 1'b0);
    run_instr(2'd0, 4'd1, 32'd0, 32'd5, 32'd0, 5'd3, 1'b0);
    run_instr(2'd2, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    run_instr(2'd1, 4'd5, 32'h1, 32'd0, 32'd40, 5'd5, 1'b0);
    run_instr(2'd3, 4'd2, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    run_instr(2'd1, 4'd12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
`ifdef KGP_ALU_ISSUE_STATS_EN
    check_val("tp_stats_issued", issued_count, 32'd5);
    check_val("tp_stats_err", {16'd0, err_count}, 32'd2);
`endif

    // randomized instruction mix
    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic [1:0]  c;
      logic [3:0]  f;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) c = 2'd0; else if (sel < 7) c = 2'd1; else if (sel < 9) c = 2'd2; else c = 2'd3;
      if (c == 2'd2) f = 4'($urandom_range(0, 6));
      else if (c == 2'd3) f = 4'($urandom);
      else f = 4'($urandom_range(0, 9));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'd0;
      run_instr(c, f, a, $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                5'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
